// File: rtl/io_arb_pkg.sv
// Shared definitions for the IO bus arbiter: transfer FSM encoding and
// requester port identifiers.
package io_arb_pkg;

    // Transfer sequencing states of the arbiter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // Requester identifiers; also the encoding of the grant index and last owner.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-request picker. A lone request always wins. On a tie the port that did
// not own the bus last wins, unless fixed_prio is set, in which case port 0
// wins every tie.
module rr_pick2
    import io_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic fixed_prio,
    output logic grant,
    output logic valid
);

    // Resolve the grant index for the current pair of requests.
    always_comb begin
        grant = PORT0;
        valid = 1'b0;
        if (req0 && req1) begin
            valid = 1'b1;
            if (fixed_prio) begin
                grant = PORT0;
            end else if (last == PORT1) begin
                grant = PORT0;
            end else begin
                grant = PORT1;
            end
        end else if (req0) begin
            valid = 1'b1;
            grant = PORT0;
        end else if (req1) begin
            valid = 1'b1;
            grant = PORT1;
        end else begin
            valid = 1'b0;
            grant = PORT0;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares one IO bus between the core (port 0) and the debug/loader master
// (port 1). One transfer is in flight at a time: IDLE samples requests,
// ISSUE drives a one-cycle strobe, reads wait one cycle for the registered
// peripheral data and acknowledge in RESP.
// Build option: define IO_ARB_FIXED_PRIO_EN to make port 0 win every tie;
// otherwise ties are resolved round-robin.
module io_bus_arbiter
    import io_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] io_address,
    output logic [DW-1:0] io_write_value,
    output logic          io_write_en,
    output logic          io_read_en,
    input  logic [DW-1:0] io_read_value
);

`ifdef IO_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          io_write_en_q, io_write_en_d;
    logic          io_read_en_q, io_read_en_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic          pick_grant_s;
    logic          pick_valid_s;
    logic          issue_next_s;
    logic          resp_next_s;

    rr_pick2 u_pick (
        .req0       (m0_req),
        .req1       (m1_req),
        .last       (last_owner_q),
        .fixed_prio (FIXED_PRIO),
        .grant      (pick_grant_s),
        .valid      (pick_valid_s)
    );

    // Next-state, transfer latching and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    state_d      = ISSUE;
                    owner_d      = pick_grant_s;
                    last_owner_d = pick_grant_s;
                    if (pick_grant_s == PORT0) begin
                        we_d    = m0_we;
                        addr_d  = m0_addr;
                        wdata_d = m0_wdata;
                    end else begin
                        we_d    = m1_we;
                        addr_d  = m1_addr;
                        wdata_d = m1_wdata;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Peripheral read data is valid in this cycle; keep it per port.
                state_d = RESP;
                if (owner_q == PORT0) begin
                    m0_rdata_d = io_read_value;
                end else begin
                    m1_rdata_d = io_read_value;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes and acks are registered from the state being entered, so
        // they never depend combinationally on a request input.
        issue_next_s  = (state_d == ISSUE);
        resp_next_s   = (state_d == RESP);
        io_write_en_d = issue_next_s & we_d;
        io_read_en_d  = issue_next_s & ~we_d;
        m0_ack_d      = ((issue_next_s & we_d) | resp_next_s) & (owner_d == PORT0);
        m1_ack_d      = ((issue_next_s & we_d) | resp_next_s) & (owner_d == PORT1);
    end

    // State and output registers; reset aborts any transfer without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= PORT0;
            last_owner_q  <= PORT1;
            we_q          <= 1'b0;
            addr_q        <= {AW{1'b0}};
            wdata_q       <= {DW{1'b0}};
            m0_rdata_q    <= {DW{1'b0}};
            m1_rdata_q    <= {DW{1'b0}};
            io_write_en_q <= 1'b0;
            io_read_en_q  <= 1'b0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            m0_rdata_q    <= m0_rdata_d;
            m1_rdata_q    <= m1_rdata_d;
            io_write_en_q <= io_write_en_d;
            io_read_en_q  <= io_read_en_d;
            m0_ack_q      <= m0_ack_d;
            m1_ack_q      <= m1_ack_d;
        end
    end

    // Address and write data only change on a grant, so outside ISSUE they
    // hold the last value driven onto the bus.
    assign io_address     = addr_q;
    assign io_write_value = wdata_q;
    assign io_write_en    = io_write_en_q;
    assign io_read_en     = io_read_en_q;
    assign m0_ack         = m0_ack_q;
    assign m1_ack         = m1_ack_q;
    assign m0_rdata       = m0_rdata_q;
    assign m1_rdata       = m1_rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized scoreboard bench for io_bus_arbiter. A transaction-level model
// of the two requesters and the bus decides grants and predicts strobe and
// ack cycles; a negedge monitor pops and compares. Honours
// IO_ARB_FIXED_PRIO_EN in the same way as the design.
module tb_io_bus_arbiter;

`ifdef IO_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] io_address, io_write_value, io_read_value;
    logic        io_write_en, io_read_en;

    io_bus_arbiter #(.AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_ack         (m0_ack),
        .m0_rdata       (m0_rdata),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_ack         (m1_ack),
        .m1_rdata       (m1_rdata),
        .io_address     (io_address),
        .io_write_value (io_write_value),
        .io_write_en    (io_write_en),
        .io_read_en     (io_read_en),
        .io_read_value  (io_read_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sq[$];        // expected IO strobes, in cycle order
    exp_t aq[$];        // expected acks, in cycle order
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   phase = 0;
    logic [31:0] hold [2];

    // Requester / bus model state
    bit          active [2];
    bit          granted [2];
    bit          dropped [2];
    bit          r_we [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    int          ack_cyc [2];
    int          idle_cyc = 0;
    bit          last_p = 1'b1;
    bit          prev_ren = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    // Peripheral read data as a fixed function of the address.
    function automatic logic [31:0] rdfun(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1234;
    endfunction

    task automatic start(input int p, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (!active[p]) begin
            active[p]     = 1'b1;
            granted[p]    = 1'b0;
            dropped[p]    = 1'b0;
            r_we[p]       = we;
            r_addr[p]     = addr;
            r_addr[p][31] = 1'(p);
            r_wdata[p]    = wdata;
        end
    endtask

    task automatic grant(input int p);
        int lat;
        lat        = r_we[p] ? 1 : 3;
        granted[p] = 1'b1;
        ack_cyc[p] = cyc + lat;
        idle_cyc   = cyc + lat + 1;
        last_p     = 1'(p);
        sq.push_back('{cyc + 1, 1'(p), r_we[p], r_addr[p], r_wdata[p]});
        aq.push_back('{cyc + lat, 1'(p), r_we[p], r_addr[p], rdfun(r_addr[p])});
    endtask

    // One clock of the model: peripheral, requesters, drive, arbitration.
    task automatic step(input int pct, input bit rd_only, input int drop_den);
        bit w0, w1;
        @(posedge clk);
        #1;
        cyc++;
        io_read_value = prev_ren ? rdfun(prev_addr) : $urandom;
        prev_ren      = io_read_en;
        prev_addr     = io_address;
        for (int p = 0; p < 2; p++) begin
            if (active[p] && granted[p] && cyc > ack_cyc[p]) active[p] = 1'b0;
            if (!active[p] && int'($urandom_range(99, 0)) < pct)
                start(p, rd_only ? 1'b0 : 1'($urandom_range(1, 0)), $urandom, $urandom);
            if (active[p] && granted[p] && !dropped[p] && drop_den > 0 &&
                $urandom_range(drop_den - 1, 0) == 0)
                dropped[p] = 1'b1;
        end
        m0_req = active[0] && !dropped[0];
        m0_we = r_we[0]; m0_addr = r_addr[0]; m0_wdata = r_wdata[0];
        m1_req = active[1] && !dropped[1];
        m1_we = r_we[1]; m1_addr = r_addr[1]; m1_wdata = r_wdata[1];
        if (cyc >= idle_cyc) begin
            w0 = active[0] && !granted[0];
            w1 = active[1] && !granted[1];
            if (w0 && w1) begin
                if (FIXED || last_p == 1'b1) grant(0);
                else grant(1);
            end else if (w0) begin
                grant(0);
            end else if (w1) begin
                grant(1);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event at cycle %0d not matched by expectation", nm, cyc);
    endtask

    // Monitor: compares DUT outputs against the expectations for this phase.
    always @(negedge clk) begin
        exp_t e;
        case (phase)
            1: begin
                hold[0] = 32'h0;
                hold[1] = 32'h0;
                chk("rst_io_write_en", {31'h0, io_write_en}, 32'h0);
                chk("rst_io_read_en", {31'h0, io_read_en}, 32'h0);
                chk("rst_io_address", io_address, 32'h0);
                chk("rst_io_write_value", io_write_value, 32'h0);
                chk("rst_m0_ack", {31'h0, m0_ack}, 32'h0);
                chk("rst_m1_ack", {31'h0, m1_ack}, 32'h0);
                chk("rst_m0_rdata", m0_rdata, 32'h0);
                chk("rst_m1_rdata", m1_rdata, 32'h0);
            end
            2: begin
                while (sq.size() > 0 && sq[0].cyc < cyc) begin
                    e = sq.pop_front();
                    fail("strobe_missing");
                end
                while (aq.size() > 0 && aq[0].cyc < cyc) begin
                    e = aq.pop_front();
                    fail("ack_missing");
                end
                if (io_write_en || io_read_en) begin
                    if (sq.size() == 0 || sq[0].cyc != cyc) begin
                        fail("strobe_unexpected");
                    end else begin
                        e = sq.pop_front();
                        chk("io_write_en", {31'h0, io_write_en}, {31'h0, e.we});
                        chk("io_read_en", {31'h0, io_read_en}, {31'h0, !e.we});
                        chk("io_address", io_address, e.addr);
                        if (e.we) chk("io_write_value", io_write_value, e.data);
                    end
                end
                if (m0_ack || m1_ack) begin
                    if (aq.size() == 0 || aq[0].cyc != cyc) begin
                        fail("ack_unexpected");
                    end else begin
                        e = aq.pop_front();
                        chk("ack_port", {30'h0, m1_ack, m0_ack}, e.port ? 32'h2 : 32'h1);
                        if (!e.we) hold[e.port] = e.data;
                    end
                end
                chk("m0_rdata", m0_rdata, hold[0]);
                chk("m1_rdata", m1_rdata, hold[1]);
            end
            3: begin
                chk("strobe_queue_empty", sq.size(), 32'h0);
                chk("ack_queue_empty", aq.size(), 32'h0);
            end
            5: begin
                chk("no_activity_after_reset", {28'h0, m1_ack, m0_ack, io_write_en, io_read_en}, 32'h0);
            end
            6: begin
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
            default: begin
            end
        endcase
    end

    initial begin
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        io_read_value = 32'h0;
        for (int p = 0; p < 2; p++) begin
            active[p] = 1'b0; granted[p] = 1'b0; dropped[p] = 1'b0; r_we[p] = 1'b0;
            r_addr[p] = 32'h0; r_wdata[p] = 32'h0; ack_cyc[p] = 0;
        end
        rst_n = 1'b0;
        phase = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        phase = 2;

        repeat (2) step(0, 1'b0, 0);
        // Single write from port 0, then a single read from port 0.
        start(0, 1'b1, 32'h4, 32'h0000_00A5);
        repeat (4) step(0, 1'b0, 0);
        start(0, 1'b0, 32'h1, 32'h0);
        repeat (6) step(0, 1'b0, 0);
        // Both ports reading continuously: grant order follows the tie rule.
        repeat (40) step(100, 1'b1, 0);
        // Back-to-back mixed transfers: requests re-raised right after ack.
        repeat (40) step(100, 1'b0, 0);
        // Random traffic with requests dropped after their grant.
        repeat (1500) step(30, 1'b0, 6);
        // Drain outstanding transfers.
        repeat (40) step(0, 1'b0, 0);
        phase = 3;
        @(posedge clk);
        #1;
        phase = 4;

        // Port 0 read aborted by reset while waiting for peripheral data.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1;
        m1_req = 1'b0;
        @(posedge clk);     // ISSUE
        @(posedge clk);     // WAIT
        #3;
        rst_n  = 1'b0;
        m0_req = 1'b0;
        phase  = 1;
        #4;
        rst_n  = 1'b1;
        phase  = 5;
        repeat (8) @(posedge clk);
        #1;
        phase = 6;
        repeat (4) @(posedge clk);
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "bench did not terminate");
    end

endmodule
